// File: rtl/mod_aes_round_engine_pkg.sv
// Shared types, S-box and round-transform functions for the iterative AES-128 round engine.
// All transforms are pure combinational functions over a 128-bit state (byte 0 at [127:120]).
package mod_aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_LAST,
    ST_DONE
  } state_e;

  localparam logic [7:0] RCON_START = 8'h01;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] get_byte(input block_t s, input int b);
    return s[127 - 8*b -: 8];
  endfunction

  function automatic logic [31:0] get_col(input block_t s, input int c);
    return s[127 - 32*c -: 32];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic block_t sub_bytes(input block_t s);
    block_t o;
    // NOTE: locals get a full default before the loop so no bit is ever left unassigned.
    o = '0;
    for (int b = 0; b < 16; b++) o[127 - 8*b -: 8] = sbox(get_byte(s, b));
    return o;
  endfunction

  function automatic block_t shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = get_byte(s, 4*((c + r) % 4) + r);
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_col(get_col(s, c));
    return o;
  endfunction

  // Each column is added independently; the carry out of a column is dropped.
  function automatic block_t col_add(input block_t s, input block_t k);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = get_col(s, c) + get_col(k, c);
    return o;
  endfunction

endpackage

// File: rtl/mod_aes_round_engine_if.sv
// Block-in / ciphertext-out valid/ready bus of the AES round engine.
interface mod_aes_round_engine_if;
  import mod_aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_data;
  block_t in_key;
  logic   mode_i;
  logic   out_valid;
  logic   out_ready;
  block_t out_data;

  modport master (
    output in_valid, in_data, in_key, mode_i, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, mode_i, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mod_aes_round_engine_key_step.sv
// One on-the-fly AES-128 key expansion step: K_{r+1} from K_r and rcon_{r+1}.
module aes_key_step
  import mod_aes_pkg::*;
(
  input  block_t     i_key,
  input  logic [7:0] i_rcon,
  output block_t     o_next_key
);

  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_temp = sub_word({i_key[23:0], i_key[31:24]}) ^ {i_rcon, 24'h000000};
  assign w_n0   = i_key[127:96] ^ w_temp;
  assign w_n1   = i_key[95:64]  ^ w_n0;
  assign w_n2   = i_key[63:32]  ^ w_n1;
  assign w_n3   = i_key[31:0]   ^ w_n2;

  assign o_next_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/mod_aes_round_engine.sv
// Iterative AES-128 encryption, one round per clock, with a selectable modified final round
// (column-wise mod-2^32 key add followed by an extra key step).
module mod_aes_round_engine
  import mod_aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int MOD_EN     = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  mod_aes_round_engine_if.slave  io_bus
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);
  localparam logic       MOD_ON   = (MOD_EN != 0);

  state_e     r_state;
  logic [3:0] r_round_cnt;
  block_t     r_st;
  block_t     r_key;
  logic [7:0] r_rcon;
  logic       r_mode;
  logic       r_in_ready;
  logic       r_out_valid;
  block_t     r_out_data;

  block_t     w_sub;
  block_t     w_round_st;
  block_t     w_std_out;
  block_t     w_mod_out;
  block_t     w_ks_key;
  logic [7:0] w_ks_rcon;
  block_t     w_key_next;
  block_t     w_key_final;

  // In IDLE the key step sees the incoming key so K1 is ready at the accept edge.
  assign w_ks_key  = (r_state == ST_IDLE) ? io_bus.in_key : r_key;
  assign w_ks_rcon = (r_state == ST_IDLE) ? RCON_START    : r_rcon;

  aes_key_step u_key_step (
    .i_key      (w_ks_key),
    .i_rcon     (w_ks_rcon),
    .o_next_key (w_key_next)
  );

  aes_key_step u_key_step_final (
    .i_key      (r_key),
    .i_rcon     (r_rcon),
    .o_next_key (w_key_final)
  );

  assign w_sub      = sub_bytes(r_st);
  assign w_round_st = mix_columns(shift_rows(w_sub)) ^ r_key;
  assign w_std_out  = shift_rows(w_sub) ^ r_key;
  assign w_mod_out  = shift_rows(col_add(w_sub, r_key)) ^ w_key_final;

  // NOTE: registers use <= so every update in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_round_cnt <= '0;
      r_st        <= '0;
      r_key       <= '0;
      r_rcon      <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_bus.in_valid) begin
            r_st        <= io_bus.in_data ^ io_bus.in_key;
            r_key       <= w_key_next;
            r_rcon      <= xtime(RCON_START);
            r_mode      <= io_bus.mode_i & MOD_ON;
            r_round_cnt <= 4'd1;
            r_in_ready  <= 1'b0;
            r_state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_st        <= w_round_st;
          r_key       <= w_key_next;
          r_rcon      <= xtime(r_rcon);
          r_round_cnt <= r_round_cnt + 4'd1;
          if (r_round_cnt == LAST_CNT) r_state <= ST_LAST;
        end
        ST_LAST: begin
          r_out_data  <= r_mode ? w_mod_out : w_std_out;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;

endmodule
